// File: rtl/gato_turn_ctrl_pkg.sv
// Shared state encoding and width helper for the Gato turn sequencer.
package gato_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_MOVE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_WIN   = 3'd2,
      ST_TIE   = 3'd3,
      ST_LOSS  = 3'd4
   } state_t;

   // Player index width never drops below one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gato_turn_ctrl_if.sv
// Player/checker-facing signal bundle of the Gato turn sequencer.
interface gato_turn_ctrl_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int MAX_MOVES   = 9
);
   import gato_pkg::*;

   localparam int PW = idx_width(NUM_PLAYERS);
   localparam int MW = $clog2(MAX_MOVES + 1);

   logic                   new_game;
   logic [NUM_PLAYERS-1:0] move_valid;
   logic                   status_valid;
   logic                   status_win;
   logic                   status_tie;
   logic                   verifica_status;
   logic [PW-1:0]          turno;
   logic [MW-1:0]          move_count;
   logic [STATE_W-1:0]     state;
   logic                   win_game;
   logic                   tie_game;
   logic                   loss_game;
   logic [PW-1:0]          player_id;

   modport master (
      output new_game, move_valid, status_valid, status_win, status_tie,
      input  verifica_status, turno, move_count, state,
             win_game, tie_game, loss_game, player_id
   );

   modport slave (
      input  new_game, move_valid, status_valid, status_win, status_tie,
      output verifica_status, turno, move_count, state,
             win_game, tie_game, loss_game, player_id
   );

endinterface

// File: rtl/gato_turn_ctrl_move_timer.sv
// Per-move timeout: down-counter reloaded on clear, expired while enabled at zero.
module gato_move_timer #(
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_in;
         assign unused_in = ^{clk, reset, clear, enable};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam int TW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
         localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

         logic [TW-1:0] cnt_q;

         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt_q <= LOAD;
            end else if (clear) begin
               cnt_q <= LOAD;
            end else if (enable && (cnt_q != '0)) begin
               cnt_q <= cnt_q - TW'(1);
            end
         end

         assign expired = enable && (cnt_q == '0);
      end
   endgenerate

endmodule

// File: rtl/gato_turn_ctrl.sv
// Gato turn sequencer: rotates turns, requests board checks, ends game on win/tie/loss.
//   state    | meaning
//   ST_MOVE  | waiting for move_valid[turno]; move timer running
//   ST_CHECK | verifica_status high, waiting for checker result
//   ST_WIN   | terminal, player_id = winner
//   ST_TIE   | terminal, board full or checker reported tie
//   ST_LOSS  | terminal, player_id = player who timed out
module gato_turn_ctrl
   import gato_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int MAX_MOVES    = 9,
   parameter int MOVE_TIMEOUT = 0
) (
   input  logic         clk,
   input  logic         reset,
   gato_turn_ctrl_if.slave bus
);

   localparam int PW = idx_width(NUM_PLAYERS);
   localparam int MW = $clog2(MAX_MOVES + 1);

   state_t        state_q, state_n;
   logic [PW-1:0] turno_q, turno_n;
   logic [MW-1:0] mc_q, mc_n;
   logic [PW-1:0] pid_q, pid_n;
   logic          vs_q, win_q, tie_q, loss_q;
   logic          expired;

   // Timer holds its reload value outside MOVE, so each move starts fresh.
   gato_move_timer #(.TIMEOUT(MOVE_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != ST_MOVE),
      .enable  (state_q == ST_MOVE),
      .expired (expired)
   );

   always_comb begin
      state_n = state_q;
      turno_n = turno_q;
      mc_n    = mc_q;
      pid_n   = pid_q;
      case (state_q)
         ST_MOVE: begin
            if (bus.move_valid[turno_q]) begin
               state_n = ST_CHECK;
               mc_n    = mc_q + MW'(1);
            end else if (expired) begin
               state_n = ST_LOSS;
               pid_n   = turno_q;
            end
         end
         ST_CHECK: begin
            if (bus.status_valid) begin
               if (bus.status_win) begin
                  state_n = ST_WIN;
                  pid_n   = turno_q;
               end else if (bus.status_tie || (mc_q == MW'(MAX_MOVES))) begin
                  state_n = ST_TIE;
               end else begin
                  state_n = ST_MOVE;
                  turno_n = (turno_q == PW'(NUM_PLAYERS - 1)) ? '0 : turno_q + PW'(1);
               end
            end
         end
         ST_WIN, ST_TIE, ST_LOSS: begin
            if (bus.new_game) begin
               state_n = ST_MOVE;
               turno_n = '0;
               mc_n    = '0;
               pid_n   = '0;
            end
         end
         default: begin
            state_n = ST_MOVE;
            turno_n = '0;
            mc_n    = '0;
            pid_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_MOVE;
         turno_q <= '0;
         mc_q    <= '0;
         pid_q   <= '0;
         vs_q    <= 1'b0;
         win_q   <= 1'b0;
         tie_q   <= 1'b0;
         loss_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         turno_q <= turno_n;
         mc_q    <= mc_n;
         pid_q   <= pid_n;
         vs_q    <= (state_n == ST_CHECK);
         win_q   <= (state_n == ST_WIN);
         tie_q   <= (state_n == ST_TIE);
         loss_q  <= (state_n == ST_LOSS);
      end
   end

   assign bus.state           = state_q;
   assign bus.turno           = turno_q;
   assign bus.move_count      = mc_q;
   assign bus.player_id       = pid_q;
   assign bus.verifica_status = vs_q;
   assign bus.win_game        = win_q;
   assign bus.tie_game        = tie_q;
   assign bus.loss_game       = loss_q;

endmodule

// File: tb/tb_gato_turn_ctrl.sv
// Scoreboard bench for gato_turn_ctrl: two configurations (2 players/no timeout, 3 players/timeout 10).
module tb_gato_turn_ctrl;
   import gato_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] tu;
      logic [3:0] mc;
      logic       vs;
      logic       w;
      logic       t;
      logic       l;
      logic [2:0] pid;
   } obs_t;

   typedef struct {
      string name;
      obs_t  v;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a, reset_b;

   gato_turn_ctrl_if #(.NUM_PLAYERS(2), .MAX_MOVES(9)) if_a ();
   gato_turn_ctrl_if #(.NUM_PLAYERS(3), .MAX_MOVES(9)) if_b ();

   gato_turn_ctrl #(.NUM_PLAYERS(2), .MAX_MOVES(9), .MOVE_TIMEOUT(0)) dut_a (
      .clk(clk), .reset(reset_a), .bus(if_a.slave));
   gato_turn_ctrl #(.NUM_PLAYERS(3), .MAX_MOVES(9), .MOVE_TIMEOUT(10)) dut_b (
      .clk(clk), .reset(reset_b), .bus(if_b.slave));

   int   total = 0;
   int   bad   = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   obs_t prev_a = '1;
   obs_t prev_b = '1;
   bit   mon_on = 1'b0;

   function automatic obs_t mk(input int st, input int tu, input int mc,
                               input int vs, input int pid);
      obs_t o;
      o.st  = 3'(st);
      o.tu  = 3'(tu);
      o.mc  = 4'(mc);
      o.vs  = 1'(vs);
      o.w   = (st == 2);
      o.t   = (st == 3);
      o.l   = (st == 4);
      o.pid = 3'(pid);
      return o;
   endfunction

   function obs_t obs_a();
      obs_t o;
      o = {if_a.state, 3'(if_a.turno), 4'(if_a.move_count), if_a.verifica_status,
           if_a.win_game, if_a.tie_game, if_a.loss_game, 3'(if_a.player_id)};
      return o;
   endfunction

   function obs_t obs_b();
      obs_t o;
      o = {if_b.state, 3'(if_b.turno), 4'(if_b.move_count), if_b.verifica_status,
           if_b.win_game, if_b.tie_game, if_b.loss_game, 3'(if_b.player_id)};
      return o;
   endfunction

   task automatic chk(input string name, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got st=%0d tu=%0d mc=%0d vs=%0b wtl=%0b%0b%0b pid=%0d, want st=%0d tu=%0d mc=%0d vs=%0b wtl=%0b%0b%0b pid=%0d",
                  name, got.st, got.tu, got.mc, got.vs, got.w, got.t, got.l, got.pid,
                  want.st, want.tu, want.mc, want.vs, want.w, want.t, want.l, want.pid);
      end
   endtask

   task automatic push(input int sel, input string name, input obs_t v);
      exp_t e;
      e.name = name;
      e.v    = v;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
   endtask

   // Every visible change of a DUT's outputs consumes one expected snapshot.
   always @(negedge clk) begin : mon_a
      obs_t cur;
      exp_t e;
      if (mon_on) begin
         cur = obs_a();
         if (cur !== prev_a) begin
            if (q_a.size() == 0) begin
               total++;
               bad++;
               $display("FAIL a_unexpected: got st=%0d tu=%0d mc=%0d, want no change",
                        cur.st, cur.tu, cur.mc);
            end else begin
               e = q_a.pop_front();
               chk(e.name, cur, e.v);
            end
            prev_a = cur;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      obs_t cur;
      exp_t e;
      if (mon_on) begin
         cur = obs_b();
         if (cur !== prev_b) begin
            if (q_b.size() == 0) begin
               total++;
               bad++;
               $display("FAIL b_unexpected: got st=%0d tu=%0d mc=%0d, want no change",
                        cur.st, cur.tu, cur.mc);
            end else begin
               e = q_b.pop_front();
               chk(e.name, cur, e.v);
            end
            prev_b = cur;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int sel, input string name);
      int left;
      for (int i = 0; i < 40; i++) begin
         left = (sel == 0) ? q_a.size() : q_b.size();
         if (left == 0) break;
         @(negedge clk);
      end
      #1;
      left = (sel == 0) ? q_a.size() : q_b.size();
      if (left != 0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: pending=%0d, want 0", name, left);
         if (sel == 0) q_a.delete();
         else          q_b.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1);
   end

   initial begin
      reset_a = 1'b0;
      reset_b = 1'b0;
      if_a.new_game = 0; if_a.move_valid = '0; if_a.status_valid = 0;
      if_a.status_win = 0; if_a.status_tie = 0;
      if_b.new_game = 0; if_b.move_valid = '0; if_b.status_valid = 0;
      if_b.status_win = 0; if_b.status_tie = 0;
      push(0, "a_reset", mk(0, 0, 0, 0, 0));
      push(1, "b_reset", mk(0, 0, 0, 0, 0));
      mon_on = 1'b1;
      repeat (3) step();
      reset_a = 1'b1;

      // Two players, P1 wins on move 2
      push(0, "t1_p0_move", mk(1, 0, 1, 1, 0));
      if_a.move_valid = 2'b01; step(); if_a.move_valid = '0;
      push(0, "t1_to_p1", mk(0, 1, 1, 0, 0));
      if_a.status_valid = 1; step(); if_a.status_valid = 0;
      push(0, "t1_p1_move", mk(1, 1, 2, 1, 0));
      if_a.move_valid = 2'b10; step(); if_a.move_valid = '0;
      push(0, "t1_win", mk(2, 1, 2, 0, 1));
      if_a.status_valid = 1; if_a.status_win = 1; step();
      if_a.status_valid = 0; if_a.status_win = 0;
      drain(0, "t1");

      // Wrong-player strobe ignored; win beats tie
      push(0, "t4_new_game", mk(0, 0, 0, 0, 0));
      if_a.new_game = 1; step(); if_a.new_game = 0;
      if_a.move_valid = 2'b10; step(); if_a.move_valid = '0;
      step();
      chk("t4_ignored_move", obs_a(), mk(0, 0, 0, 0, 0));
      push(0, "t4_p0_move", mk(1, 0, 1, 1, 0));
      if_a.move_valid = 2'b11; step(); if_a.move_valid = '0;
      push(0, "t4_win_over_tie", mk(2, 0, 1, 0, 0));
      if_a.status_valid = 1; if_a.status_win = 1; if_a.status_tie = 1; step();
      if_a.status_valid = 0; if_a.status_win = 0; if_a.status_tie = 0;
      drain(0, "t4");

      // Reset in CHECK, new_game ignored in CHECK, new_game from TIE
      push(0, "t5_new_game", mk(0, 0, 0, 0, 0));
      if_a.new_game = 1; step(); if_a.new_game = 0;
      push(0, "t5_p0_move", mk(1, 0, 1, 1, 0));
      if_a.move_valid = 2'b01; step(); if_a.move_valid = '0;
      if_a.new_game = 1; step(); if_a.new_game = 0;
      chk("t5_new_game_in_check", obs_a(), mk(1, 0, 1, 1, 0));
      push(0, "t5_reset_in_check", mk(0, 0, 0, 0, 0));
      reset_a = 1'b0; if_a.status_valid = 1; if_a.status_win = 1; step();
      reset_a = 1'b1; if_a.status_valid = 0; if_a.status_win = 0;
      chk("t5_after_reset", obs_a(), mk(0, 0, 0, 0, 0));
      push(0, "t5_p0_move2", mk(1, 0, 1, 1, 0));
      if_a.move_valid = 2'b01; step(); if_a.move_valid = '0;
      push(0, "t5_tie", mk(3, 0, 1, 0, 0));
      if_a.status_valid = 1; if_a.status_tie = 1; step();
      if_a.status_valid = 0; if_a.status_tie = 0;
      if_a.move_valid = 2'b01; step(); step(); if_a.move_valid = '0;
      chk("t5_tie_held", obs_a(), mk(3, 0, 1, 0, 0));
      push(0, "t5_new_game_from_tie", mk(0, 0, 0, 0, 0));
      if_a.new_game = 1; step(); if_a.new_game = 0;
      drain(0, "t5");

      // Timeout 10: LOSS exactly on the tenth edge after release
      reset_b = 1'b1;
      push(1, "t3_loss", mk(4, 0, 0, 0, 0));
      repeat (9) step();
      chk("t3_cycle9_still_move", obs_b(), mk(0, 0, 0, 0, 0));
      step();
      chk("t3_cycle10_loss", obs_b(), mk(4, 0, 0, 0, 0));
      drain(1, "t3a");

      // Move on the last allowed cycle beats the timeout
      push(1, "t3_new_game", mk(0, 0, 0, 0, 0));
      if_b.new_game = 1; step(); if_b.new_game = 0;
      repeat (9) step();
      push(1, "t3_late_move", mk(1, 0, 1, 1, 0));
      if_b.move_valid = 3'b001; step(); if_b.move_valid = '0;
      chk("t3_accept_not_loss", obs_b(), mk(1, 0, 1, 1, 0));
      push(1, "t2_to_p1", mk(0, 1, 1, 0, 0));
      if_b.status_valid = 1; step(); if_b.status_valid = 0;

      // Three players, nine moves with no result -> forced TIE
      for (int i = 1; i < 9; i++) begin
         int tu;
         tu = i % 3;
         push(1, $sformatf("t2_move%0d", i + 1), mk(1, tu, i + 1, 1, 0));
         if_b.move_valid = 3'(1 << tu); step(); if_b.move_valid = '0;
         if (i == 4) repeat (3) step();
         if (i == 8) push(1, "t2_tie", mk(3, tu, 9, 0, 0));
         else        push(1, $sformatf("t2_next%0d", i + 1), mk(0, (tu + 1) % 3, i + 1, 0, 0));
         if_b.status_valid = 1; step(); if_b.status_valid = 0;
      end
      drain(1, "t2");
      push(1, "t2_new_game", mk(0, 0, 0, 0, 0));
      if_b.new_game = 1; step(); if_b.new_game = 0;
      drain(1, "t2b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
